mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Four-port round-robin arbiter in front of a single DDR burst controller.
// Port indices are fixed: 0=rd0, 1=wr0, 2=rd1, 3=wr1. Only one burst is
// outstanding downstream at a time. The winner's index, length and address
// are latched on selection. The owner then receives a one-cycle grant
// together with the downstream request. Read valids, write data requests and
// the finish pulse are routed to the owner only.
//
// Ports
//   ddr_clk_i, ddr_rst_n_i       clock, async active-low reset
//   local_init_done_i            DDR calibration complete; low aborts a burst
//   rdK_* / wrK_* (K=0,1)        upstream request/grant/data/finish per port
//   rd_ddr_* / wr_ddr_* / ddr_*  downstream burst controller handshake
//   arb_owner_o, arb_busy_o      latched owner index, burst in progress
//   arb_abort_o                  one-cycle pulse when init drops mid-burst
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int  ADDR_WIDTH    = 30,
    parameter int  MEM_DATA_BITS = 256,
    // Kept for drop-in compatibility with the original controller; the
    // registers here are modelled without clock-to-q delay.
    parameter real TCQ           = 0.1
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_n_i,
    input  logic                     local_init_done_i,
    // read port 0
    input  logic                     rd0_req_i,
    input  logic [7:0]               rd0_len_i,
    input  logic [ADDR_WIDTH-1:0]    rd0_addr_i,
    output logic                     rd0_gnt_o,
    output logic                     rd0_data_valid_o,
    output logic                     rd0_finish_o,
    // read port 1
    input  logic                     rd1_req_i,
    input  logic [7:0]               rd1_len_i,
    input  logic [ADDR_WIDTH-1:0]    rd1_addr_i,
    output logic                     rd1_gnt_o,
    output logic                     rd1_data_valid_o,
    output logic                     rd1_finish_o,
    output logic [MEM_DATA_BITS-1:0] rd_data_o,
    // write port 0
    input  logic                     wr0_req_i,
    input  logic [7:0]               wr0_len_i,
    input  logic [ADDR_WIDTH-1:0]    wr0_addr_i,
    input  logic [MEM_DATA_BITS-1:0] wr0_data_i,
    output logic                     wr0_gnt_o,
    output logic                     wr0_data_req_o,
    output logic                     wr0_finish_o,
    // write port 1
    input  logic                     wr1_req_i,
    input  logic [7:0]               wr1_len_i,
    input  logic [ADDR_WIDTH-1:0]    wr1_addr_i,
    input  logic [MEM_DATA_BITS-1:0] wr1_data_i,
    output logic                     wr1_gnt_o,
    output logic                     wr1_data_req_o,
    output logic                     wr1_finish_o,
    // downstream burst controller
    output logic                     rd_ddr_req_o,
    output logic                     wr_ddr_req_o,
    output logic [7:0]               ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    ddr_addr_o,
    output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
    input  logic                     rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
    input  logic                     rd_ddr_finish_i,
    input  logic                     wr_ddr_data_req_i,
    input  logic                     wr_ddr_finish_i,
    // status
    output logic [1:0]               arb_owner_o,
    output logic                     arb_busy_o,
    output logic                     arb_abort_o
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_e;

    arb_state_e            state_q, state_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [1:0]            owner_q, owner_d;
    logic [7:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  unused_tcq;
    assign unused_tcq = (TCQ >= 0.0);

    // Request vector in port-index order.
    logic [3:0] req_vec;
    assign req_vec = {wr1_req_i, rd1_req_i, wr0_req_i, rd0_req_i};

    // Round-robin search starting at rr_ptr_q. Iterating from the farthest
    // offset down lets the nearest requester overwrite earlier hits.
    logic [1:0] win_idx;
    logic       win_found;
    always_comb begin
        logic [1:0] idx;
        idx       = 2'd0;
        win_idx   = rr_ptr_q;
        win_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr_q + 2'(i);
            if (req_vec[idx]) begin
                win_idx   = idx;
                win_found = 1'b1;
            end
        end
    end

    logic [7:0]            sel_len;
    logic [ADDR_WIDTH-1:0] sel_addr;
    always_comb begin
        sel_len  = rd0_len_i;
        sel_addr = rd0_addr_i;
        case (win_idx)
            2'd1:    begin sel_len = wr0_len_i; sel_addr = wr0_addr_i; end
            2'd2:    begin sel_len = rd1_len_i; sel_addr = rd1_addr_i; end
            2'd3:    begin sel_len = wr1_len_i; sel_addr = wr1_addr_i; end
            default: begin sel_len = rd0_len_i; sel_addr = rd0_addr_i; end
        endcase
    end

    // Odd indices are write ports.
    logic       owner_is_wr;
    logic [3:0] own_vec;
    logic       own_ddr_finish;
    assign owner_is_wr    = owner_q[0];
    assign own_vec        = 4'b0001 << owner_q;
    assign own_ddr_finish = owner_is_wr ? wr_ddr_finish_i : rd_ddr_finish_i;

    logic [3:0] gnt_vec, fin_vec;
    logic       rd_req, wr_req, abort;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        len_d    = len_q;
        addr_d   = addr_q;
        gnt_vec  = 4'b0000;
        fin_vec  = 4'b0000;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (local_init_done_i && win_found) begin
                    owner_d  = win_idx;
                    len_d    = sel_len;
                    addr_d   = sel_addr;
                    rr_ptr_d = win_idx + 2'd1;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (!local_init_done_i) begin
                    fin_vec = own_vec;
                    abort   = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    gnt_vec = own_vec;
                    if (len_q == 8'd0) begin
                        // Empty burst completes without touching downstream.
                        fin_vec = own_vec;
                        state_d = ARB_IDLE;
                    end else begin
                        rd_req  = ~owner_is_wr;
                        wr_req  = owner_is_wr;
                        state_d = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                if (!local_init_done_i) begin
                    fin_vec = own_vec;
                    abort   = 1'b1;
                    state_d = ARB_IDLE;
                end else if (own_ddr_finish) begin
                    fin_vec = own_vec;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= 2'd0;
            owner_q  <= 2'd0;
            len_q    <= 8'd0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
        end
    end

    // Data-phase routing is only live while a burst is outstanding.
    logic       in_busy;
    logic [3:0] vld_vec, dreq_vec;
    assign in_busy  = (state_q == ARB_BUSY);
    assign vld_vec  = (rd_ddr_data_valid_i && in_busy && !owner_is_wr) ? own_vec : 4'b0000;
    assign dreq_vec = (wr_ddr_data_req_i   && in_busy &&  owner_is_wr) ? own_vec : 4'b0000;

    always_comb begin
        case (owner_q)
            2'd1:    wr_ddr_data_o = wr0_data_i;
            2'd3:    wr_ddr_data_o = wr1_data_i;
            default: wr_ddr_data_o = '0;
        endcase
    end

    assign rd0_gnt_o        = gnt_vec[0];
    assign wr0_gnt_o        = gnt_vec[1];
    assign rd1_gnt_o        = gnt_vec[2];
    assign wr1_gnt_o        = gnt_vec[3];
    assign rd0_finish_o     = fin_vec[0];
    assign wr0_finish_o     = fin_vec[1];
    assign rd1_finish_o     = fin_vec[2];
    assign wr1_finish_o     = fin_vec[3];
    assign rd0_data_valid_o = vld_vec[0];
    assign rd1_data_valid_o = vld_vec[2];
    assign wr0_data_req_o   = dreq_vec[1];
    assign wr1_data_req_o   = dreq_vec[3];
    assign rd_data_o        = rd_ddr_data_i;

    assign rd_ddr_req_o = rd_req;
    assign wr_ddr_req_o = wr_req;
    assign ddr_len_o    = len_q;
    assign ddr_addr_o   = addr_q;
    assign arb_owner_o  = owner_q;
    assign arb_busy_o   = (state_q != ARB_IDLE);
    assign arb_abort_o  = abort;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
    localparam int AW = 30;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init;
    always #5 clk = ~clk;

    // bench-side request model: port index order 0=rd0,1=wr0,2=rd1,3=wr1
    logic [3:0]    req_m;
    logic [7:0]    len_m  [4];
    logic [AW-1:0] addr_m [4];
    logic [DW-1:0] wdat   [2];
    logic [DW-1:0] rdat;
    logic          ds_rd_vld, ds_rd_fin, ds_wr_dreq, ds_wr_fin;

    logic rd0_gnt, rd0_vld, rd0_fin, rd1_gnt, rd1_vld, rd1_fin;
    logic wr0_gnt, wr0_dreq, wr0_fin, wr1_gnt, wr1_dreq, wr1_fin;
    logic rd_ddr_req, wr_ddr_req, busy, abort;
    logic [7:0]    ddr_len;
    logic [AW-1:0] ddr_addr;
    logic [DW-1:0] rd_data, wr_ddr_data;
    logic [1:0]    owner;

    mem_req_arbiter dut (
        .ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .local_init_done_i(init),
        .rd0_req_i(req_m[0]), .rd0_len_i(len_m[0]), .rd0_addr_i(addr_m[0]),
        .rd0_gnt_o(rd0_gnt), .rd0_data_valid_o(rd0_vld), .rd0_finish_o(rd0_fin),
        .rd1_req_i(req_m[2]), .rd1_len_i(len_m[2]), .rd1_addr_i(addr_m[2]),
        .rd1_gnt_o(rd1_gnt), .rd1_data_valid_o(rd1_vld), .rd1_finish_o(rd1_fin),
        .rd_data_o(rd_data),
        .wr0_req_i(req_m[1]), .wr0_len_i(len_m[1]), .wr0_addr_i(addr_m[1]),
        .wr0_data_i(wdat[0]), .wr0_gnt_o(wr0_gnt), .wr0_data_req_o(wr0_dreq),
        .wr0_finish_o(wr0_fin),
        .wr1_req_i(req_m[3]), .wr1_len_i(len_m[3]), .wr1_addr_i(addr_m[3]),
        .wr1_data_i(wdat[1]), .wr1_gnt_o(wr1_gnt), .wr1_data_req_o(wr1_dreq),
        .wr1_finish_o(wr1_fin),
        .rd_ddr_req_o(rd_ddr_req), .wr_ddr_req_o(wr_ddr_req),
        .ddr_len_o(ddr_len), .ddr_addr_o(ddr_addr), .wr_ddr_data_o(wr_ddr_data),
        .rd_ddr_data_valid_i(ds_rd_vld), .rd_ddr_data_i(rdat),
        .rd_ddr_finish_i(ds_rd_fin), .wr_ddr_data_req_i(ds_wr_dreq),
        .wr_ddr_finish_i(ds_wr_fin),
        .arb_owner_o(owner), .arb_busy_o(busy), .arb_abort_o(abort)
    );

    wire [3:0] gnt_v  = {wr1_gnt, rd1_gnt, wr0_gnt, rd0_gnt};
    wire [3:0] fin_v  = {wr1_fin, rd1_fin, wr0_fin, rd0_fin};
    wire [3:0] vld_v  = {1'b0, rd1_vld, 1'b0, rd0_vld};
    wire [3:0] dreq_v = {wr1_dreq, 1'b0, wr0_dreq, 1'b0};

    int n_chk = 0;
    int n_err = 0;
    int rr_m  = 0;   // model round-robin pointer

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_w();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // First requesting port at or after the pointer, wrapping mod 4.
    function automatic int pick(input logic [3:0] m, input int rr);
        for (int i = 0; i < 4; i++) if (m[(rr + i) % 4]) return (rr + i) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int p);
        return 4'b0001 << p;
    endfunction

    task automatic ds_clear();
        ds_rd_vld = 0; ds_rd_fin = 0; ds_wr_dreq = 0; ds_wr_fin = 0;
    endtask

    task automatic ds_junk();
        ds_rd_vld = 1'($urandom); ds_rd_fin = 1'($urandom);
        ds_wr_dreq = 1'($urandom); ds_wr_fin = 1'($urandom);
    endtask

    // One full arbitration: IDLE cycle (requests added), ISSUE cycle, and,
    // for non-empty bursts, data beats plus a finish. Inputs change at
    // negedge, outputs sampled 1 time unit later, before the next posedge.
    task automatic do_txn(input logic [3:0] add, input int fp,
                          input logic [7:0] fl, input logic [AW-1:0] fa);
        int w, odd;
        logic [7:0] el;
        logic [AW-1:0] ea;
        @(negedge clk);
        init = 1;
        ds_junk();
        if (fp >= 0 && !req_m[fp]) begin
            req_m[fp] = 1; len_m[fp] = fl; addr_m[fp] = fa;
        end
        if (req_m == 0 && add == 0) add = 4'b0001;
        for (int p = 0; p < 4; p++) if (add[p] && !req_m[p]) begin
            req_m[p] = 1; len_m[p] = 8'($urandom_range(0, 4)); addr_m[p] = AW'($urandom);
        end
        #1;
        check("idle_busy", DW'(busy), DW'(0));
        check("idle_gnt",  DW'(gnt_v), DW'(0));
        check("idle_route", DW'({vld_v, dreq_v, fin_v}), DW'(0));
        w = pick(req_m, rr_m); el = len_m[w]; ea = addr_m[w]; odd = w % 2;

        @(negedge clk);
        ds_junk();
        #1;
        check("issue_gnt",   DW'(gnt_v), DW'(onehot(w)));
        check("issue_rdreq", DW'(rd_ddr_req), DW'(el != 0 && odd == 0));
        check("issue_wrreq", DW'(wr_ddr_req), DW'(el != 0 && odd == 1));
        check("issue_len",   DW'(ddr_len), DW'(el));
        check("issue_addr",  DW'(ddr_addr), DW'(ea));
        check("issue_owner", DW'(owner), DW'(w));
        check("issue_busy",  DW'(busy), DW'(1));
        check("issue_fin",   DW'(fin_v), DW'(el == 0 ? onehot(w) : 4'b0));
        check("issue_route", DW'({vld_v, dreq_v}), DW'(0));
        req_m[w] = 0;
        rr_m = (w + 1) % 4;
        if (el == 0) return;

        // wrong-direction finish must not complete the burst
        @(negedge clk);
        ds_clear();
        if (odd == 1) ds_rd_fin = 1; else ds_wr_fin = 1;
        #1;
        check("busy_xfin", DW'(fin_v), DW'(0));
        for (int b = 0; b < el; b++) begin
            @(negedge clk);
            ds_clear();
            rdat = rand_w(); wdat[0] = rand_w(); wdat[1] = rand_w();
            if (odd == 1) ds_wr_dreq = 1; else ds_rd_vld = 1;
            #1;
            check("beat_vld",   DW'(vld_v),  DW'(odd == 0 ? onehot(w) : 4'b0));
            check("beat_dreq",  DW'(dreq_v), DW'(odd == 1 ? onehot(w) : 4'b0));
            check("beat_rdata", rd_data, rdat);
            check("beat_wdata", wr_ddr_data, odd == 1 ? wdat[w/2] : '0);
            check("beat_len",   DW'(ddr_len), DW'(el));
        end
        @(negedge clk);
        ds_clear();
        if (odd == 1) ds_wr_fin = 1; else ds_rd_fin = 1;
        #1;
        check("fin_vec",   DW'(fin_v), DW'(onehot(w)));
        check("fin_abort", DW'(abort), DW'(0));
    endtask

    initial begin
        rst_n = 0; init = 0; req_m = 0; rdat = '0;
        wdat[0] = '0; wdat[1] = '0;
        for (int p = 0; p < 4; p++) begin len_m[p] = 0; addr_m[p] = 0; end
        ds_clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  DW'(busy), DW'(0));
        check("rst_owner", DW'(owner), DW'(0));
        check("rst_outs",  DW'({gnt_v, fin_v, rd_ddr_req, wr_ddr_req, abort}), DW'(0));
        check("rst_len",   DW'({ddr_len, ddr_addr}), DW'(0));
        @(negedge clk);
        rst_n = 1;

        // single rd0 burst, len 4 at 0x100
        do_txn(4'b0000, 0, 8'd4, AW'(32'h100));
        // all four ports requesting continuously
        for (int i = 0; i < 5; i++) do_txn(4'b1111, -1, 8'd0, '0);
        // randomized traffic
        for (int i = 0; i < 40; i++) do_txn(4'($urandom_range(0, 15)), -1, 8'd0, '0);

        // init drops mid read burst
        req_m = 0;
        @(negedge clk);
        ds_clear(); req_m[2] = 1; len_m[2] = 8'd3; addr_m[2] = AW'($urandom);
        #1;
        @(negedge clk);
        #1;
        check("ab_gnt", DW'(gnt_v), DW'(onehot(2)));
        req_m[2] = 0; rr_m = 3;
        @(negedge clk);
        ds_rd_vld = 1; rdat = rand_w();
        #1;
        check("ab_vld", DW'(vld_v), DW'(onehot(2)));
        @(negedge clk);
        ds_clear(); init = 0;
        #1;
        check("ab_fin",   DW'(fin_v), DW'(onehot(2)));
        check("ab_pulse", DW'(abort), DW'(1));
        req_m[0] = 1; len_m[0] = 8'd1; addr_m[0] = AW'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ds_rd_vld = 1;
            #1;
            check("ab_idle", DW'({busy, abort, gnt_v, fin_v, vld_v}), DW'(0));
        end
        ds_clear();
        do_txn(4'b0000, -1, 8'd0, '0);

        // reset asserted mid write burst (wr0 leaves pointer at 2)
        req_m = 0;
        @(negedge clk);
        req_m[1] = 1; len_m[1] = 8'd4; addr_m[1] = AW'($urandom);
        #1;
        @(negedge clk);
        #1;
        check("rs_gnt", DW'(gnt_v), DW'(onehot(1)));
        req_m[1] = 0;
        @(negedge clk);
        ds_wr_dreq = 1; wdat[0] = rand_w();
        #1;
        check("rs_dreq", DW'(dreq_v), DW'(onehot(1)));
        #1;
        rst_n = 0;
        #1;
        check("rs_async", DW'({busy, owner, gnt_v, fin_v, dreq_v, rd_ddr_req, wr_ddr_req, abort}), DW'(0));
        check("rs_latch", DW'({ddr_len, ddr_addr}), DW'(0));
        check("rs_wdata", wr_ddr_data, '0);
        rr_m = 0;
        @(negedge clk);
        ds_clear(); rst_n = 1;
        do_txn(4'b1111, -1, 8'd0, '0);
        do_txn(4'b0000, -1, 8'd0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
